bisng_corr: RTL

Correlated bipolar stochastic number generator. It converts two signed binary operands into a pair of maximally correlated bipolar bitstreams. Both streams are compared against one shared LFSR sequence. It sits directly upstream of the in-stream correlated bipolar divide/square-root unit and its `cordiv` core, which need the dividend and divisor streams to share a random source. Each run emits exactly one full LFSR period, so the ones-count of each stream is exact.

---
 rtl/bisng_if.sv | 31 +++
 rtl/bisng_corr.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bisng_if.sv
// Handshake and stream bundle for the correlated bipolar SNG.
//   start, val_a, val_b   : run request and two's-complement operands
//   seed_load, seed       : LFSR seed update (honoured only while idle)
//   busy                  : run in progress
//   out_a, out_b, out_vld : stream bits and their valid flag
//   done                  : pulse with the last valid bit of a run
// master drives requests (the producer of operands); slave is the generator.
interface bisng_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] val_a;
  logic [WIDTH-1:0] val_b;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             busy;
  logic             out_a;
  logic             out_b;
  logic             out_vld;
  logic             done;

  modport master (
    output start, val_a, val_b, seed_load, seed,
    input  busy, out_a, out_b, out_vld, done
  );

  modport slave (
    input  start, val_a, val_b, seed_load, seed,
    output busy, out_a, out_b, out_vld, done
  );
endinterface

// File: rtl/bisng_corr.sv
// Correlated bipolar stochastic number generator.
// Two signed operands are offset to unsigned and compared every cycle against one
// shared maximal-length LFSR, giving two maximally correlated bitstreams. Each run
// is exactly one LFSR period (2^WIDTH-1 bits), so each ones-count equals the offset
// operand exactly.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : bisng_if slave (start/val_a/val_b/seed_load/seed in;
//           busy/out_a/out_b/out_vld/done out)
module bisng_corr #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h5A)
) (
  input logic     clk,
  input logic     rst_n,
  bisng_if.slave  bus
);

  generate
    if (!(WIDTH == 8 || WIDTH == 10 || WIDTH == 12 || WIDTH == 16)) begin : gen_bad_width
      $error("bisng_corr: WIDTH must be 8, 10, 12 or 16");
    end
    if (SEED == '0) begin : gen_bad_seed
      $error("bisng_corr: SEED must be nonzero");
    end
  endgenerate

  // Tap positions expressed as a mask over the current state (bit tap-1).
  localparam logic [15:0] TapMaskFull = (WIDTH == 8)  ? 16'h00B8 :
                                        (WIDTH == 10) ? 16'h0240 :
                                        (WIDTH == 12) ? 16'h0829 : 16'hD008;
  localparam logic [WIDTH-1:0] TapMask  = TapMaskFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MsbFlip  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CntFull  = '1;
  localparam logic [WIDTH-1:0] CntPenul = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] cnt_q;     // number of bits emitted in the current run
  logic [WIDTH-1:0] off_a_q, off_b_q;
  logic             out_a_q, out_b_q, out_vld_q, done_q;

  logic             last_bit;
  logic             b2b;
  logic             accept_idle;
  logic             emit;
  logic             seed_upd;
  logic [WIDTH-1:0] off_a_in, off_b_in;
  logic [WIDTH-1:0] cmp_lfsr, cmp_off_a, cmp_off_b;
  logic             done_d;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TapMask)};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StRun;
      StRun:  if (cnt_q == CntFull && !bus.start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath control
  always_comb begin
    off_a_in    = bus.val_a ^ MsbFlip;
    off_b_in    = bus.val_b ^ MsbFlip;
    last_bit    = (state_q == StRun) && (cnt_q == CntFull);
    accept_idle = (state_q == StIdle) && bus.start;
    // A start in the last-bit cycle restarts immediately: the new run's first bit
    // is produced on this edge from the fresh operands and the seed, so no gap.
    b2b         = last_bit && bus.start;
    emit        = ((state_q == StRun) && !last_bit) || b2b;
    seed_upd    = (state_q == StIdle) && bus.seed_load && (bus.seed != '0);
    cmp_lfsr    = b2b ? seed_q   : lfsr_q;
    cmp_off_a   = b2b ? off_a_in : off_a_q;
    cmp_off_b   = b2b ? off_b_in : off_b_q;
    done_d      = emit && !b2b && (cnt_q == CntPenul);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_q    <= SEED;
      lfsr_q    <= SEED;
      cnt_q     <= '0;
      off_a_q   <= '0;
      off_b_q   <= '0;
      out_a_q   <= 1'b0;
      out_b_q   <= 1'b0;
      out_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (seed_upd) begin
        seed_q <= bus.seed;
      end
      if (accept_idle || b2b) begin
        off_a_q <= off_a_in;
        off_b_q <= off_b_in;
      end
      if (accept_idle) begin
        lfsr_q <= seed_q;
        cnt_q  <= '0;
      end else if (emit) begin
        lfsr_q <= lfsr_step(cmp_lfsr);
        cnt_q  <= b2b ? WIDTH'(1) : cnt_q + WIDTH'(1);
      end
      out_vld_q <= emit;
      out_a_q   <= emit && (cmp_off_a >= cmp_lfsr);
      out_b_q   <= emit && (cmp_off_b >= cmp_lfsr);
      done_q    <= done_d;
    end
  end

  assign bus.busy    = (state_q == StRun);
  assign bus.out_a   = out_a_q;
  assign bus.out_b   = out_b_q;
  assign bus.out_vld = out_vld_q;
  assign bus.done    = done_q;

endmodule
